bg_ram_arbiter: RTL and testbench
=================================

BG_RAM_ARBITER -- requirements
Module: bg_ram_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of tile-write requesters (score, ground, coin, ghost).
REQ-002 Parameter TILE_COUNT, default 1200, number of background tiles (40 columns x 30 rows) covered by a clear.
REQ-003 Parameter AW, default 16, RAM address width.
REQ-004 Parameter DW, default 32, RAM data width.
REQ-005 Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 Port: reset, input, 1, asynchronous active-low reset.
REQ-007 Port: hold, input, 1, high suspends all grants and clear progress (game_on low).
REQ-008 Port: clear_start, input, 1, single-cycle request to zero the whole background RAM.
REQ-009 Port: req, input, N_REQ, per-requester write request, level, held until granted.
REQ-010 Port: req_addr, input, N_REQ*AW, packed per-requester tile address; requester i uses slice i.
REQ-011 Port: req_data, input, N_REQ*DW, packed per-requester tile word; requester i uses slice i.
REQ-012 Port: gnt, output, N_REQ, combinational one-hot grant for the current cycle.
REQ-013 Port: bg_ram_addr, output, AW, registered RAM write address.
REQ-014 Port: bg_ram_data, output, DW, registered RAM write data.
REQ-015 Port: bg_wea, output, 1, registered RAM write enable.
REQ-016 Port: clear_busy, output, 1, high while in CLEAR state.
REQ-017 Port: clear_done, output, 1, one-cycle pulse when the final clear write is on the outputs.

Function
REQ-018 The block SHALL implement two states: ARB and CLEAR; reset state ARB.
REQ-019 In ARB with hold low and clear_start low, gnt SHALL be one-hot for the first set req bit searching upward from rr_ptr with wrap-around, else all zero.
REQ-020 In ARB, a clear_start high cycle SHALL force gnt to zero and move to CLEAR with clear counter 0 at the next edge; pending req bits wait.
REQ-021 On the edge ending a cycle with gnt[i] high, outputs SHALL register bg_ram_addr=req_addr[i], bg_ram_data=req_data[i], bg_wea=1, and rr_ptr SHALL become (i+1) mod N_REQ.
REQ-022 On any edge with no grant and no clear write, bg_wea SHALL register 0 while bg_ram_addr/bg_ram_data hold their values.
REQ-023 A requester SHALL treat gnt[i] high as consumption of the current addr/data; it may change them or drop req from the next cycle.
REQ-024 In CLEAR with hold low and counter c, the next edge SHALL register bg_ram_addr=c, bg_ram_data=0, bg_wea=1 and increment c.
REQ-025 When c equals TILE_COUNT-1 at that edge, state SHALL return to ARB and clear_done SHALL register 1 for exactly that one cycle.
REQ-026 In CLEAR, gnt SHALL be all zero, and clear_start SHALL be ignored (no restart).
REQ-027 hold high SHALL freeze state, counter and rr_ptr, force gnt to zero, and register bg_wea=0.
REQ-028 A clear SHALL produce exactly TILE_COUNT consecutive writes, addresses 0..TILE_COUNT-1 ascending, when hold stays low.
REQ-029 The clear counter SHALL be $clog2(TILE_COUNT) bits; rr_ptr SHALL be $clog2(N_REQ) bits, wrapping modulo N_REQ.

Reset
REQ-030 Reset low SHALL asynchronously set state=ARB, counter=0, rr_ptr=0, bg_wea=0, bg_ram_addr=0, bg_ram_data=0, clear_done=0; clear_busy is then 0.
REQ-031 Reset asserted mid-clear SHALL abort the clear; no clear_done is produced.

Structure
REQ-032 TILE_COLS=40, TILE_ROWS=30, TILE_COUNT, AW, DW and the ARB/CLEAR state enum SHALL live in shared package bg_arb_pkg.
REQ-033 The round-robin picker SHALL be one combinational sub-module rr_arbiter (inputs req, rr_ptr, enable; output one-hot gnt).

Verification
REQ-034 Reset release, req=4'b0101 held, addr0=5/addr2=9 -> gnt 0001, 0100, 0001 on successive cycles; writes to 5, 9, 5 appear one cycle after each grant.
REQ-035 clear_start pulse while req=4'b1111 -> gnt stays 0 for 1201 cycles, 1200 writes of data 0 to addresses 0..1199, clear_done high with the address-1199 write, then grants resume at the saved rr_ptr.
REQ-036 hold high for 10 cycles mid-clear at address 300 -> bg_wea=0 for those cycles, writes resume at 300, and the total write count is 1200.
REQ-037 Reset asserted at clear address 600 -> outputs zero immediately, state ARB, no clear_done; a new clear_start restarts at 0.
REQ-038 req=4'b1000 with rr_ptr=3, then req=4'b1001 -> gnt 1000, then 0001 (wrap), rr_ptr=1.

Source files
------------

// File: rtl/bg_arb_pkg.sv
// Shared definitions for the background-RAM write arbiter.
// Holds the tile-map geometry, RAM bus widths, the arbiter state type and a
// helper that sizes index/counter registers.
package bg_arb_pkg;

    localparam int unsigned TILE_COLS  = 40;
    localparam int unsigned TILE_ROWS  = 30;
    localparam int unsigned TILE_COUNT = TILE_COLS * TILE_ROWS;
    localparam int unsigned AW         = 16;
    localparam int unsigned DW         = 32;

    typedef enum logic [0:0] {
        StArb,
        StClear
    } arb_state_e;

    // Width needed to index n items; never below one bit so n == 1 still
    // yields a legal vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req_i  - request vector, one bit per requester
//   ptr_i  - highest-priority requester index for this cycle
//   en_i   - when low, no grant is issued
//   gnt_o  - one-hot grant (all zero when disabled or nothing requested)
module rr_arbiter
    import bg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan upward from ptr_i with wrap-around; the first set bit wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        if (en_i) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                idx = PW'((32'(ptr_i) + k) % N_REQ);
                if (!found && req_i[idx]) begin
                    gnt_o[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bg_ram_arbiter.sv
// Background tile-RAM write arbiter.
// Serialises tile writes from several requesters onto one registered RAM
// write port with round-robin fairness, and can sweep the whole background
// to zero on demand.
// Ports:
//   clk, reset               - clock, asynchronous active-low reset
//   hold                     - freezes grants and clear progress
//   clear_start              - one-cycle request to zero the background RAM
//   req/req_addr/req_data    - per-requester write request, packed address/data
//   gnt                      - combinational one-hot grant
//   bg_ram_addr/data/wea     - registered RAM write port
//   clear_busy, clear_done   - clear in progress / final clear write on outputs
module bg_ram_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned TILE_COUNT = bg_arb_pkg::TILE_COUNT,
    parameter int unsigned AW         = bg_arb_pkg::AW,
    parameter int unsigned DW         = bg_arb_pkg::DW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              clear_start,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]  gnt,
    output logic [AW-1:0]     bg_ram_addr,
    output logic [DW-1:0]     bg_ram_data,
    output logic              bg_wea,
    output logic              clear_busy,
    output logic              clear_done
);

    import bg_arb_pkg::idx_width;
    import bg_arb_pkg::arb_state_e;
    import bg_arb_pkg::StArb;
    import bg_arb_pkg::StClear;

    localparam int unsigned PW = idx_width(N_REQ);
    localparam int unsigned CW = idx_width(TILE_COUNT);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rr_q, rr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          wea_q, wea_d;
    logic          done_q, done_d;

    logic          arb_en;
    logic [PW-1:0] gnt_idx;
    logic [AW-1:0] addr_arr [N_REQ];
    logic [DW-1:0] data_arr [N_REQ];

    // A clear request in the same cycle pre-empts any grant.
    assign arb_en = (state_q == StArb) && !hold && !clear_start;

    rr_arbiter #(
        .N_REQ(N_REQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req_i(req),
        .ptr_i(rr_q),
        .en_i (arb_en),
        .gnt_o(gnt)
    );

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            addr_arr[i] = req_addr[i*AW +: AW];
            data_arr[i] = req_data[i*DW +: DW];
        end
    end

    // Encode the one-hot grant back to an index.
    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = PW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wea_d   = 1'b0;
        done_d  = 1'b0;

        if (!hold) begin
            unique case (state_q)
                StArb: begin
                    if (clear_start) begin
                        state_d = StClear;
                        cnt_d   = '0;
                    end else if (|gnt) begin
                        addr_d = addr_arr[gnt_idx];
                        data_d = data_arr[gnt_idx];
                        wea_d  = 1'b1;
                        rr_d   = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
                StClear: begin
                    addr_d = AW'(cnt_q);
                    data_d = '0;
                    wea_d  = 1'b1;
                    if (cnt_q == CW'(TILE_COUNT - 1)) begin
                        state_d = StArb;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StArb;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StArb;
            cnt_q   <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wea_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wea_q   <= wea_d;
            done_q  <= done_d;
        end
    end

    assign bg_ram_addr = addr_q;
    assign bg_ram_data = data_q;
    assign bg_wea      = wea_q;
    assign clear_done  = done_q;
    assign clear_busy  = (state_q == StClear);

endmodule

// File: tb/tb_bg_ram_arbiter.sv
module tb_bg_ram_arbiter;

    import bg_arb_pkg::*;

    localparam int NR = 4;

    logic              clk;
    logic              reset;
    logic              hold;
    logic              clear_start;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     gnt;
    logic [AW-1:0]     bg_ram_addr;
    logic [DW-1:0]     bg_ram_data;
    logic              bg_wea;
    logic              clear_busy;
    logic              clear_done;

    int total = 0;
    int bad   = 0;

    bg_ram_arbiter #(
        .N_REQ     (NR),
        .TILE_COUNT(TILE_COUNT),
        .AW        (AW),
        .DW        (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .clear_start(clear_start),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .gnt        (gnt),
        .bg_ram_addr(bg_ram_addr),
        .bg_ram_data(bg_ram_data),
        .bg_wea     (bg_wea),
        .clear_busy (clear_busy),
        .clear_done (clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          hold;
        logic [NR-1:0] req;
        logic [NR-1:0] gnt;
        logic          wea;
        logic [15:0]   addr;
        logic [31:0]   data;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs are stable from the call; gnt/busy sampled at the falling edge,
    // registered outputs sampled 1 time unit after the rising edge.
    task automatic tick(output logic [NR-1:0] g, output logic b);
        @(negedge clk);
        g = gnt;
        b = clear_busy;
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Runs one clear from the clear_start pulse. Holds when the next expected
    // address equals hold_at; returns early (still in CLEAR) when it equals rst_at.
    task automatic do_clear(input int hold_at, input int hold_len, input int rst_at,
                            output int nwr, output int nerr, output int ndone,
                            output int ngnt, output int nhold);
        logic [NR-1:0] g;
        logic          b;
        int            exp;
        int            held;
        nwr = 0; nerr = 0; ndone = 0; ngnt = 0; nhold = 0;
        exp = 0; held = 0;
        clear_start = 1'b1;
        tick(g, b);
        if (g != '0) ngnt++;
        clear_start = 1'b0;
        for (int cyc = 0; cyc < 3000 && exp < TILE_COUNT; cyc++) begin
            if (rst_at >= 0 && exp == rst_at) break;
            hold = (exp == hold_at && held < hold_len);
            tick(g, b);
            if (g != '0) ngnt++;
            if (!b) nerr++;
            if (hold) begin
                held++;
                nhold++;
                if (bg_wea || clear_done) nerr++;
            end else if (bg_wea && bg_ram_addr == AW'(exp) && bg_ram_data == '0) begin
                nwr++;
                if (clear_done) begin
                    ndone++;
                    if (exp != TILE_COUNT - 1) nerr++;
                end
                exp++;
            end else begin
                nerr++;
            end
        end
        hold = 1'b0;
    endtask

    initial begin
        logic [NR-1:0] g;
        logic          b;
        int nwr, nerr, ndone, ngnt, nhold;
        // reference model
        bit            m_clear;
        int            m_c, m_ptr, j;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_data;
        logic          m_wea, m_done;
        logic [NR-1:0] exp_g;
        int            egnt, ebusy, eout;

        vecs[0] = '{1'b0, 4'b0101, 4'b0001, 1'b1, 16'd5,  32'hDA7A_0000};
        vecs[1] = '{1'b0, 4'b0101, 4'b0100, 1'b1, 16'd9,  32'hDA7A_0002};
        vecs[2] = '{1'b0, 4'b0101, 4'b0001, 1'b1, 16'd5,  32'hDA7A_0000};
        vecs[3] = '{1'b0, 4'b0100, 4'b0100, 1'b1, 16'd9,  32'hDA7A_0002};
        vecs[4] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 16'd11, 32'hDA7A_0003};
        vecs[5] = '{1'b0, 4'b1001, 4'b0001, 1'b1, 16'd5,  32'hDA7A_0000};
        vecs[6] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 16'd5,  32'hDA7A_0000};
        vecs[7] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 16'd5,  32'hDA7A_0000};
        vecs[8] = '{1'b0, 4'b1111, 4'b0010, 1'b1, 16'd7,  32'hDA7A_0001};

        reset = 1'b0; hold = 1'b0; clear_start = 1'b0; req = '0;
        req_addr = '0; req_data = '0;
        set_slot(0, 16'd5,  32'hDA7A_0000);
        set_slot(1, 16'd7,  32'hDA7A_0001);
        set_slot(2, 16'd9,  32'hDA7A_0002);
        set_slot(3, 16'd11, 32'hDA7A_0003);

        repeat (2) @(posedge clk);
        #1;
        check("rst_wea",  bg_wea, 0);
        check("rst_addr", bg_ram_addr, 0);
        check("rst_data", bg_ram_data, 0);
        check("rst_done", clear_done, 0);
        check("rst_busy", clear_busy, 0);
        reset = 1'b1;

        // Basic round-robin and wrap sequences
        for (int i = 0; i < 9; i++) begin
            hold = vecs[i].hold;
            req  = vecs[i].req;
            tick(g, b);
            check($sformatf("vec%0d_gnt", i),  g, vecs[i].gnt);
            check($sformatf("vec%0d_wea", i),  bg_wea, vecs[i].wea);
            check($sformatf("vec%0d_addr", i), bg_ram_addr, vecs[i].addr);
            check($sformatf("vec%0d_data", i), bg_ram_data, vecs[i].data);
        end
        hold = 1'b0;
        // rr_ptr is now 2

        // Full clear with all requesters pending
        req = 4'b1111;
        do_clear(-1, 0, -1, nwr, nerr, ndone, ngnt, nhold);
        check("clr1_writes", nwr, TILE_COUNT);
        check("clr1_errs", nerr, 0);
        check("clr1_done", ndone, 1);
        check("clr1_gnt_nonzero", ngnt, 0);
        tick(g, b);
        check("clr1_busy_after", b, 0);
        check("clr1_resume_gnt", g, 4'b0100);
        check("clr1_resume_addr", bg_ram_addr, 9);
        check("clr1_done_after", clear_done, 0);

        // Clear with a 10-cycle hold at address 300
        do_clear(300, 10, -1, nwr, nerr, ndone, ngnt, nhold);
        check("clr2_writes", nwr, TILE_COUNT);
        check("clr2_errs", nerr, 0);
        check("clr2_done", ndone, 1);
        check("clr2_held", nhold, 10);
        check("clr2_gnt_nonzero", ngnt, 0);
        tick(g, b);
        check("clr2_resume_gnt", g, 4'b1000);
        check("clr2_resume_addr", bg_ram_addr, 11);

        // Reset in the middle of a clear
        do_clear(-1, 0, 600, nwr, nerr, ndone, ngnt, nhold);
        check("clr3_writes", nwr, 600);
        check("clr3_errs", nerr, 0);
        check("clr3_done", ndone, 0);
        reset = 1'b0;
        #1;
        check("clr3_rst_wea", bg_wea, 0);
        check("clr3_rst_addr", bg_ram_addr, 0);
        check("clr3_rst_data", bg_ram_data, 0);
        check("clr3_rst_busy", clear_busy, 0);
        check("clr3_rst_done", clear_done, 0);
        tick(g, b);
        reset = 1'b1;
        req = '0;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            tick(g, b);
            if (clear_done || b) ndone++;
        end
        check("clr3_no_done", ndone, 0);
        do_clear(-1, 0, -1, nwr, nerr, ndone, ngnt, nhold);
        check("clr4_writes", nwr, TILE_COUNT);
        check("clr4_errs", nerr, 0);
        check("clr4_done", ndone, 1);

        // Randomised run against a behavioural model
        reset = 1'b0;
        tick(g, b);
        reset = 1'b1;
        m_clear = 0; m_c = 0; m_ptr = 0;
        m_addr = '0; m_data = '0; m_wea = 0; m_done = 0;
        egnt = 0; ebusy = 0; eout = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            req         = NR'($urandom);
            hold        = ($urandom_range(7) == 0);
            clear_start = ($urandom_range(299) == 0);
            for (int i = 0; i < NR; i++) set_slot(i, AW'($urandom), DW'($urandom));

            exp_g = '0;
            j = -1;
            if (!m_clear && !hold && !clear_start) begin
                for (int k = 0; k < NR; k++) begin
                    if (j < 0 && req[(m_ptr + k) % NR]) j = (m_ptr + k) % NR;
                end
                if (j >= 0) exp_g[j] = 1'b1;
            end

            tick(g, b);
            if (g !== exp_g) egnt++;
            if (b !== m_clear) ebusy++;

            m_wea = 0;
            m_done = 0;
            if (!hold) begin
                if (m_clear) begin
                    m_addr = AW'(m_c);
                    m_data = '0;
                    m_wea = 1;
                    if (m_c == TILE_COUNT - 1) begin
                        m_clear = 0;
                        m_c = 0;
                        m_done = 1;
                    end else begin
                        m_c++;
                    end
                end else if (clear_start) begin
                    m_clear = 1;
                    m_c = 0;
                end else if (j >= 0) begin
                    m_addr = req_addr[j*AW +: AW];
                    m_data = req_data[j*DW +: DW];
                    m_wea = 1;
                    m_ptr = (j + 1) % NR;
                end
            end
            if (bg_wea !== m_wea || clear_done !== m_done ||
                bg_ram_addr !== m_addr || bg_ram_data !== m_data) eout++;
        end
        hold = 1'b0;
        clear_start = 1'b0;
        check("rand_gnt_errs", egnt, 0);
        check("rand_busy_errs", ebusy, 0);
        check("rand_out_errs", eout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
